// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the CPU data bus.
//
// The CPU stores bytes to TXDATA (BASE_ADDR+0). They queue in a small TX
// FIFO, and a bit-serial engine sends each one as a frame: a low start bit,
// eight data bits LSB first, then a high stop bit. STATUS (BASE_ADDR+4) is
// read combinationally. Writing STATUS with bit 3 set clears the sticky
// overflow flag.
//
// STATUS layout:
//   [0] full   [1] empty   [2] busy   [3] overflow   [15:8] FIFO count
//
// Optional feature: define MMIO_UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
//
// Ports:
//   clock  in   system clock, all state updates on the rising edge
//   reset  in   asynchronous, active-low reset
//   we     in   store strobe from the CPU
//   a      in   byte address; only a[31:2] is decoded
//   wd     in   store data
//   rd     out  read data: STATUS when a hits STATUS, otherwise 0
//   hit    out  a[31:2] selects TXDATA or STATUS
//   tx     out  registered serial line, idles high
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [29:0] TXDATA_WORD = BASE_ADDR[31:2];
    localparam logic [29:0] STATUS_WORD = BASE_ADDR[31:2] + 30'd1;

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               hit_tx, hit_st;
    logic               push_req, push, pop;
    logic               full, empty, busy, baud_wrap;
    logic [7:0]         count_ext;
    logic [31:0]        status;
    logic               unused_bits;

    // ---------------------------------------------------------------
    // Bus decode and status
    // ---------------------------------------------------------------
    assign hit_tx = (a[31:2] == TXDATA_WORD);
    assign hit_st = (a[31:2] == STATUS_WORD);
    assign hit    = hit_tx | hit_st;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != S_IDLE);
    assign count_ext = 8'(count_q);
    assign status    = {16'h0000, count_ext, 4'h0, ovf_q, busy, empty, full};
    assign rd        = hit_st ? status : 32'h0000_0000;

    // Only the low byte of a store and the word part of the address matter.
    assign unused_bits = ^{a[1:0], wd[31:8]};

    // ---------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------
    // The engine only pops while idle, so a pop always means "load the
    // head into the shift register on this edge".
    assign pop      = (state_q == S_IDLE) & ~empty;
    assign push_req = we & hit_tx;
    // A push into a full FIFO still succeeds when the same edge frees a slot.
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_req & ~push) begin
            ovf_d = 1'b1;
        end else if (we & hit_st & wd[3]) begin
            ovf_d = 1'b0;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wd[7:0];
        end
    end

    // ---------------------------------------------------------------
    // Serial engine
    // ---------------------------------------------------------------
    assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == S_IDLE) begin
            baud_d = '0;
            bit_d  = '0;
        end else begin
            baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    shift_d  = mem[rd_ptr_q];
`ifdef MMIO_UART_TX_PARITY_EN
                    parity_d = ^mem[rd_ptr_q];
`endif
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge as the state it belongs to.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A timeline model predicts FIFO acceptance, status and the expected byte
// stream; a serial monitor decodes frames from tx and checks them against
// the expected-byte queue.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF0000;
    localparam logic [31:0] STAT  = 32'hFFFF0004;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          FB    = 11;
`else
    localparam int          FB    = 10;
`endif
    localparam int          FRAME = FB * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] a     = STAT;
    logic [31:0] wd    = 32'h0;
    logic [31:0] rd;
    logic        hit;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .hit   (hit),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Reference model: FIFO as a queue, engine as a timeline. A byte popped
    // at edge P occupies the line for FRAME cycles, the engine is idle
    // again after edge P+FRAME and can pop next at edge P+FRAME+1.
    // ---------------------------------------------------------------
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    int         m_t      = 0;
    int         next_pop = 0;
    int         busy_end = 0;
    logic       m_ovf    = 1'b0;
    logic       m_busy   = 1'b0;
    logic       m_pop;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_t      = 0;
            next_pop = 0;
            busy_end = 0;
            m_ovf    = 1'b0;
            m_busy   = 1'b0;
        end else begin
            m_pop = (m_fifo.size() != 0) && (m_t >= next_pop);
            if (m_pop) begin
                void'(m_fifo.pop_front());
                next_pop = m_t + FRAME + 1;
                busy_end = m_t + FRAME;
            end
            if (we && a[31:2] == BASE[31:2]) begin
                if (m_fifo.size() < DEPTH) begin
                    m_fifo.push_back(wd[7:0]);
                    exp_q.push_back(wd[7:0]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (we && a[31:2] == STAT[31:2] && wd[3]) begin
                m_ovf = 1'b0;
            end
            m_busy = (m_t < busy_end);
            m_t++;
        end
    end

    function automatic logic [31:0] model_status();
        int n;
        n = m_fifo.size();
        return {16'h0000, 8'(n), 4'h0, m_ovf, m_busy, (n == 0), (n == DEPTH)};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bus(input string name);
        logic [31:0] exp_rd;
        logic        exp_hit;
        #1;
        exp_hit = (a[31:2] == BASE[31:2]) || (a[31:2] == STAT[31:2]);
        exp_rd  = (a[31:2] == STAT[31:2]) ? model_status() : 32'h0;
        check_val({name, "_rd"}, rd, exp_rd);
        check_val({name, "_hit"}, {31'h0, hit}, {31'h0, exp_hit});
    endtask

    task automatic cyc_drive(input logic w, input logic [31:0] adr, input logic [31:0] d);
        @(negedge clk);
        we = w;
        a  = adr;
        wd = d;
        check_bus("bus");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b0, STAT, 32'h0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((m_fifo.size() != 0 || m_busy || exp_q.size() != 0) && n < 3000) begin
            idle(1);
            n++;
        end
        check_val({name, "_drain_timeout"}, {31'h0, (n >= 3000)}, 32'h0);
        idle(2);
    endtask

    // ---------------------------------------------------------------
    // Serial monitor: samples tx on every falling clock edge.
    // ---------------------------------------------------------------
    int         starts[$];
    logic       s [FRAME];
    logic       prev;
    logic       aborted;
    logic       shape_ok;
    logic [7:0] got;
    logic [7:0] e;
    int         st;

    initial begin
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                st      = cyc;
                s[0]    = tx;
                aborted = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[k] = tx;
                end
                if (aborted) begin
                    prev = 1'b1;
                end else begin
                    shape_ok = 1'b1;
                    for (int b = 0; b < FB; b++)
                        for (int j = 0; j < CPB; j++)
                            if (s[b*CPB+j] !== s[b*CPB]) shape_ok = 1'b0;
                    if (s[0] !== 1'b0) shape_ok = 1'b0;
                    if (s[(FB-1)*CPB] !== 1'b1) shape_ok = 1'b0;
                    for (int i = 0; i < 8; i++) got[i] = s[(i+1)*CPB];
`ifdef MMIO_UART_TX_PARITY_EN
                    if (s[9*CPB] !== ^got) shape_ok = 1'b0;
`endif
                    check_val("frame_shape", {31'h0, shape_ok}, 32'h1);
                    starts.push_back(st);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL frame_byte: got 0x%02h, expected 0x%02h", got, e);
                        end
                    end
                    $display("frame byte=0x%02h start_cycle=%0d", got, st);
                    prev = s[FRAME-1];
                end
            end else begin
                prev = tx;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    int          sc;
    int          lows;
    int          r;
    logic [31:0] adr;
    logic [31:0] addr_pool [6];

    initial begin
        addr_pool[0] = BASE;
        addr_pool[1] = STAT;
        addr_pool[2] = BASE + 32'd5;
        addr_pool[3] = BASE + 32'd8;
        addr_pool[4] = BASE - 32'd4;
        addr_pool[5] = BASE + 32'd2;

        // Reset and idle state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("reset_tx", {31'h0, tx}, 32'h1);
        check_val("reset_status", rd, 32'h0000_0002);
        check_val("reset_hit", {31'h0, hit}, 32'h1);
        cyc_drive(1'b0, BASE + 32'd8, 32'h0);
        check_val("unmapped_hit", {31'h0, hit}, 32'h0);
        check_val("unmapped_rd", rd, 32'h0);
        cyc_drive(1'b0, BASE, 32'h0);
        check_val("txdata_read_rd", rd, 32'h0);

        // Single byte: latency, busy and frame contents
        starts.delete();
        cyc_drive(1'b1, BASE, 32'h55);
        @(posedge clk);
        #1 sc = cyc;
        idle(20);
        check_val("busy_mid_frame", {31'h0, rd[2]}, 32'h1);
        drain("single");
        check_val("single_status_after", rd, 32'h0000_0002);
        if (starts.size() > 0) check_val("start_latency", starts[0], sc + 1);
        else check_val("start_latency_missing", 32'(starts.size()), 32'h1);

        // Overflow burst, then overflow clear
        starts.delete();
        for (int i = 0; i < 10; i++) cyc_drive(1'b1, BASE, i);
        cyc_drive(1'b1, STAT, 32'h0);
        check_val("ovf_status", rd, 32'h0000_080D);
        cyc_drive(1'b1, STAT, 32'h8);
        check_val("ovf_kept", rd, 32'h0000_080D);
        cyc_drive(1'b0, STAT, 32'h0);
        check_val("ovf_cleared", rd, 32'h0000_0805);
        drain("burst");
        check_val("burst_frames", 32'(starts.size()), 32'd9);
        for (int i = 1; i < 9 && i < starts.size(); i++)
            check_val("frame_gap", starts[i] - starts[i-1], FRAME + 1);

        // Parity patterns (also plain frames when parity is disabled)
        cyc_drive(1'b1, BASE, 32'h07);
        cyc_drive(1'b1, BASE, 32'h03);
        drain("parity");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                cyc_drive(1'b1, BASE, $urandom);
            end else if (r < 16) begin
                cyc_drive(1'b1, STAT, $urandom);
            end else if (r < 20) begin
                adr = (r < 18) ? addr_pool[$urandom_range(3, 4)] : $urandom;
                cyc_drive(1'b1, adr, $urandom);
            end else begin
                cyc_drive(1'b0, addr_pool[$urandom_range(0, 5)], $urandom);
            end
        end
        drain("random");

        // Reset during data bit 3
        cyc_drive(1'b1, BASE, 32'hA5);
        @(posedge clk);
        #1 sc = cyc;
        while (cyc < sc + 18) idle(1);
        #1;
        check_val("tx_bit3", {31'h0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_val("tx_async_reset", {31'h0, tx}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cyc_drive(1'b0, STAT, 32'h0);
        check_val("post_reset_status", rd, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_val("tx_quiet_after_reset", lows, 32'h0);

        check_val("pending_frames", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, beside dmem; consumes the same store signals the CPU drives (mem_write, data_adr, write_data).
- CPU stores bytes into a TX FIFO; a bit-serial engine shifts each byte out on a single line.
- Exposes a combinational status word on the read path and an address-hit flag for the system read mux.

Parameters:
- BASE_ADDR, 32'hFFFF0000, word-aligned base address; TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4.
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.

Ports:
- clock, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-low reset.
- we, input, 1, store strobe from CPU (mem_write).
- a, input, 32, byte address (data_adr); decode uses a[31:2] only.
- wd, input, 32, store data (write_data).
- rd, output, 32, read data; combinational.
- hit, output, 1, combinational; 1 when a[31:2] matches TXDATA or STATUS.
- tx, output, 1, serial line; registered; idles high.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, FIFO empty (pointers and count 0), overflow=0, FSM=IDLE, bit and baud counters 0. rd and hit follow a combinationally.
- STATUS layout: [0] full, [1] empty, [2] busy (FSM != IDLE), [3] overflow (sticky), [7:4] 0, [15:8] FIFO count, [31:16] 0.
- rd = STATUS when a hits STATUS; otherwise 0, including TXDATA reads.
- Push: we=1 and a hits TXDATA. Enqueues wd[7:0] at the posedge.
  - If full and no pop on that edge, the byte is dropped and overflow is set.
  - Push and pop on the same edge: both occur; count is unchanged, even when full.
- Overflow clear: we=1, a hits STATUS, wd[3]=1 clears overflow. Other STATUS bits are read-only. Writes to unmapped addresses are ignored.
- FSM:
  - IDLE: tx=1. If FIFO non-empty at a posedge: pop the head into the shift register, go to START. IDLE always lasts at least 1 cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - A push at posedge N into an empty FIFO with FSM in IDLE: pop and tx falling at posedge N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 idle-high cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The FSM advances only on the wrap.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: tx goes high immediately, and the frame and FIFO contents are discarded. After release, no residual bits are sent.

Optional Feature:
- Macro: MMIO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT cycles.
- Undefined: no parity state; DATA goes directly to STOP; frame length is 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release; read STATUS -> tx=1, rd=0x00000002, hit=1; a=BASE_ADDR+8 -> hit=0, rd=0.
- Single byte (CLKS_PER_BIT=4): store 0x55 to BASE_ADDR.
  - tx low 1 cycle after the store edge, for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles (frame 40 cycles).
  - STATUS bit2=1 during the frame, 0 afterwards; STATUS=0x00000002 afterwards.
- Overflow (FIFO_DEPTH=8): 10 stores on consecutive cycles (0x00..0x09).
  - The first byte pops, bytes 2..9 fill the FIFO, the 10th is dropped.
  - STATUS=0x0000080D.
  - Serial output is exactly 0x00..0x08, each frame separated by 1 idle cycle.
- Overflow clear: store 0x0 to STATUS -> overflow still 1; store 0x8 -> STATUS bit3=0; count and other bits unchanged.
- Reset mid-frame: assert reset during data bit 3 -> tx=1 in the same cycle. After release, STATUS=0x00000002 and tx stays high for 100 cycles.
- Parity (macro defined): store 0x07 -> 11-bit frame with parity bit=1. Store 0x03 -> parity bit=0. Macro undefined: stop bit follows bit 7 directly.
